// File: rtl/lane_serializer_pkg.sv
// Shared definitions for the 4-lane serializer.
//   LANES       : number of parallel lanes in one input group
//   lane_idx_t  : lane index / last-lane length type
//   ser_state_e : serializer FSM states
package lane_serializer_pkg;

    localparam int LANES = 4;

    typedef logic [1:0] lane_idx_t;

    typedef enum logic {
        SER_IDLE,
        SER_SEND
    } ser_state_e;

endpackage

// File: rtl/lane_serializer_4.sv
// Serializes one 4-lane group of DATA_WIDTH-bit words into a stream of
// single-word beats, lane 0 first, tagging each beat with its lane index and
// a last-beat marker.
//
// Ports:
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   in_valid, in_ready  : input group handshake
//   in_data1..in_data4  : lane 0..3 words
//   in_len              : index of the last lane to emit (0 = lane 0 only)
//   out_valid, out_ready: output beat handshake
//   out_data            : current lane word
//   out_lane            : lane index of the current beat
//   out_last            : high on the final beat of the group
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. The producer holds valid and its payload stable until the
// transfer; the consumer may change ready freely. While out_valid is high and
// out_ready is low, every output holds its value.
module lane_serializer_4
    import lane_serializer_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data1,
    input  logic [DATA_WIDTH-1:0] in_data2,
    input  logic [DATA_WIDTH-1:0] in_data3,
    input  logic [DATA_WIDTH-1:0] in_data4,
    input  logic [1:0]            in_len,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [1:0]            out_lane,
    output logic                  out_last
);

    ser_state_e            state;
    ser_state_e            state_next;
    logic [DATA_WIDTH-1:0] lane_buf [LANES];
    lane_idx_t             idx;
    lane_idx_t             len;
    logic                  last_beat;
    logic                  capture;
    logic                  advance;
    logic                  go_idle;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SER_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and handshake outputs.
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        advance    = 1'b0;
        go_idle    = 1'b0;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        last_beat  = (idx == len);
        case (state)
            SER_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    capture    = 1'b1;
                    state_next = SER_SEND;
                end
            end
            SER_SEND: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (last_beat) begin
                        // The final beat leaves this edge, so a waiting group
                        // can be taken in the same cycle with no bubble. This
                        // makes in_ready combinational on out_ready.
                        in_ready = 1'b1;
                        if (in_valid) begin
                            capture = 1'b1;
                        end else begin
                            go_idle    = 1'b1;
                            state_next = SER_IDLE;
                        end
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            default: begin
                state_next = SER_IDLE;
            end
        endcase
    end

    // Group buffer, captured length and beat index. idx only counts up to
    // len, so it never wraps past lane 3.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LANES; i++) begin
                lane_buf[i] <= '0;
            end
            idx <= '0;
            len <= '0;
        end else if (capture) begin
            lane_buf[0] <= in_data1;
            lane_buf[1] <= in_data2;
            lane_buf[2] <= in_data3;
            lane_buf[3] <= in_data4;
            len         <= in_len;
            idx         <= '0;
        end else if (advance) begin
            idx <= idx + 2'd1;
        end else if (go_idle) begin
            idx <= '0;
        end
    end

    assign out_data = lane_buf[idx];
    assign out_lane = idx;
    assign out_last = out_valid && last_beat;

endmodule

// File: tb/tb_lane_serializer_4.sv
module tb_lane_serializer_4;

    localparam int W = 16;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data1;
    logic [W-1:0] in_data2;
    logic [W-1:0] in_data3;
    logic [W-1:0] in_data4;
    logic [1:0]   in_len;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [1:0]   out_lane;
    logic         out_last;

    // Expected beat packed as {last, lane, data}.
    logic [W+2:0] exp_q[$];

    int errors = 0;
    int checks = 0;

    lane_serializer_4 #(.DATA_WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data1 (in_data1),
        .in_data2 (in_data2),
        .in_data3 (in_data3),
        .in_data4 (in_data4),
        .in_len   (in_len),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_lane (out_lane),
        .out_last (out_last)
    );

    // Clock and reset.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Driver: present a group, wait (bounded) for acceptance, then push the
    // beats it should produce.
    task automatic send_group(input logic [W-1:0] d0, input logic [W-1:0] d1,
                              input logic [W-1:0] d2, input logic [W-1:0] d3,
                              input logic [1:0] len);
        logic [W-1:0] words [4];
        logic         acc;
        words[0] = d0; words[1] = d1; words[2] = d2; words[3] = d3;
        in_data1 = d0; in_data2 = d1; in_data3 = d2; in_data4 = d3;
        in_len   = len;
        in_valid = 1'b1;
        acc      = 1'b0;
        for (int c = 0; c < 100 && !acc; c++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!acc) begin
            chk("accept_timeout", 32'd0, 32'd1);
        end else begin
            for (int i = 0; i <= int'(len); i++) begin
                exp_q.push_back({(i == int'(len)), 2'(i), words[i]});
            end
        end
    endtask

    task automatic wait_drain();
        for (int c = 0; c < 100 && exp_q.size() != 0; c++) tick();
        chk("drain", exp_q.size(), 0);
    endtask

    // Scoreboard monitor: compares every accepted beat against the queue.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", {13'd0, out_last, out_lane, out_data}, 32'hFFFF_FFFF);
            end else begin
                logic [W+2:0] e;
                e = exp_q.pop_front();
                chk("beat_data", out_data, e[W-1:0]);
                chk("beat_lane", out_lane, e[W+1:W]);
                chk("beat_last", out_last, e[W+2]);
                chk("beat_in_ready", in_ready, e[W+2]);
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data1  = '0;
        in_data2  = '0;
        in_data3  = '0;
        in_data4  = '0;
        in_len    = 2'd0;
        out_ready = 1'b1;
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_lane", out_lane, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Full group, out_ready held high.
        send_group(16'h0011, 16'h0022, 16'h0033, 16'h0044, 2'd3);
        wait_drain();
        tick();
        chk("idle_out_valid", out_valid, 0);
        chk("idle_in_ready", in_ready, 1);

        // Back-to-back groups: out_valid must stay high for 8 beats.
        fork
            begin
                send_group(16'h0011, 16'h0022, 16'h0033, 16'h0044, 2'd3);
                send_group(16'hA000, 16'hA001, 16'hA002, 16'hA003, 2'd3);
            end
            begin
                int c;
                c = 0;
                @(negedge clk);
                while (!out_valid && c < 50) begin
                    @(negedge clk);
                    c++;
                end
                for (int b = 0; b < 8; b++) begin
                    chk("b2b_out_valid", out_valid, 1);
                    @(negedge clk);
                end
            end
        join
        wait_drain();
        tick();

        // Backpressure during lane 1.
        send_group(16'h0011, 16'h0022, 16'h0033, 16'h0044, 2'd3);
        tick();
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            tick();
            chk("stall_out_valid", out_valid, 1);
            chk("stall_out_data", out_data, 16'h0022);
            chk("stall_out_lane", out_lane, 1);
            chk("stall_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        wait_drain();
        tick();

        // Short group of one beat.
        send_group(16'hBEEF, 16'h1111, 16'h2222, 16'h3333, 2'd0);
        tick();
        chk("short_out_valid", out_valid, 0);
        chk("short_in_ready", in_ready, 1);
        chk("short_drain", exp_q.size(), 0);

        // in_len changed after capture has no effect.
        send_group(16'h5001, 16'h5002, 16'h5003, 16'h5004, 2'd1);
        in_len = 2'd3;
        tick();
        tick();
        tick();
        chk("len_out_valid", out_valid, 0);
        chk("len_drain", exp_q.size(), 0);

        // Reset in the middle of a group.
        send_group(16'hC000, 16'hC001, 16'hC002, 16'hC003, 2'd3);
        tick();
        tick();
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_lane", out_lane, 0);
        chk("midrst_out_last", out_last, 0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int s = 0; s < 4; s++) begin
            tick();
            chk("postrst_out_valid", out_valid, 0);
        end
        send_group(16'hD000, 16'hD001, 16'hD002, 16'hD003, 2'd2);
        chk("postrst_first_lane", out_lane, 0);
        chk("postrst_first_data", out_data, 16'hD000);
        wait_drain();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lane_serializer_4.md
Name: lane_serializer_4

Overview:
- Consumes one 4-lane group of parallel DATA_WIDTH-bit results, such as the four registered sums from the 4-lane adder stage.
- Emits the group as a serial stream, one lane per beat, with lane index and last-beat marker.
- Sits between the parallel arithmetic lanes and the single-word result path.
- Valid/ready handshake on both sides, zero-bubble back-to-back groups.

Parameters:
- DATA_WIDTH, 16, width of each lane word and of out_data.

Ports:
- clk  input  1  clock, all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  input group valid.
- in_ready  output  1  block can accept a group this cycle.
- in_data1  input  DATA_WIDTH  lane 0 word.
- in_data2  input  DATA_WIDTH  lane 1 word.
- in_data3  input  DATA_WIDTH  lane 2 word.
- in_data4  input  DATA_WIDTH  lane 3 word.
- in_len  input  2  index of the last lane to emit: 0 sends lane 0 only, 3 sends all four.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts the beat.
- out_data  output  DATA_WIDTH  current lane word.
- out_lane  output  2  lane index of the current beat.
- out_last  output  1  high on the beat where out_lane == stored in_len.

Behaviour:
- Clock and reset: single clock clk; rst_n asynchronous, active-low.
- Reset values: state IDLE, out_valid 0, out_lane 0, out_last 0, out_data 0. The buffer is cleared to 0. in_ready is 1 after reset (it is combinational from state).
- Input transfer: in_valid && in_ready at a rising edge. Output transfer: out_valid && out_ready at a rising edge.
- States:
  - IDLE: out_valid 0, in_ready 1. On input transfer, capture the 4 words and in_len, set idx = 0, go to SEND.
  - SEND: out_valid 1, out_data = buf[idx], out_lane = idx, out_last = (idx == len).
    - Output transfer with idx != len: idx increments.
    - Output transfer with idx == len, and in_valid at the same edge: capture the new group, idx = 0, stay in SEND (no bubble).
    - Output transfer with idx == len, no in_valid: go to IDLE.
    - No output transfer: all outputs and the buffer hold stable (AXI-style, no change while stalled).
- in_ready = (state == IDLE) || (out_valid && out_ready && out_last). This combinational path from out_ready is intentional.
- Latency: a group accepted at edge t presents lane 0 with out_valid high after edge t. A full group with out_ready held high takes 4 beats.
- Sustained throughput: one beat per cycle, including across group boundaries.
- Words pass through unmodified; no arithmetic, no width change.
- in_len is sampled only at input transfer. Later changes have no effect on the group in flight.
- in_data* changes while in_ready is low are ignored.
- in_valid with in_ready low: no capture, and the upstream must hold.
- Reset asserted mid-group: in-flight words are discarded immediately (asynchronous), the block returns to IDLE, and no partial beat follows deassertion.
- idx never exceeds len and does not wrap past 3.

Decomposition:
- Shared package lane_serializer_pkg holds:
  - LANES = 4;
  - lane_idx_t (logic [1:0]);
  - state enum ser_state_e {SER_IDLE, SER_SEND}.
- No sub-module: one module containing the state register, the 4-entry buffer, idx/len registers and the output mux. Target 150-250 lines.

Test Plan:
- Reset, then in_data1..4 = 0x0011, 0x0022, 0x0033, 0x0044, in_len = 3, out_ready = 1 -> beats 0x0011/lane0, 0x0022/1, 0x0033/2, 0x0044/3 on 4 consecutive cycles; out_last only on lane 3; in_ready high on the lane-3 cycle.
- Back-to-back: second group 0xA000..0xA003 held valid during the first group -> 8 consecutive beats with out_valid continuously 1, no idle cycle between 0x0044 and 0xA000.
- Backpressure: out_ready = 0 for 3 cycles during lane 1 -> out_data = 0x0022, out_lane = 1 and out_valid stay stable; in_ready stays 0; the stream resumes with lane 2.
- Short group: in_len = 0 with data 0xBEEF -> a single beat 0xBEEF, lane 0, out_last = 1, then return to IDLE (out_valid 0, in_ready 1).
- in_len = 1 with in_len changed to 3 after capture -> exactly 2 beats, out_last on lane 1.
- Reset mid-group: assert rst_n = 0 after lane 1 is emitted -> out_valid drops asynchronously; after release no beats appear until a new in_valid; the next group starts at lane 0.
